apb_master_arbiter: RTL

//   Shares one APB completer (e.g. the memory-mapped slave) between NREQ requesters.

---
 rtl/apb_master_arbiter_pkg.sv | 12 +
 rtl/apb_master_arbiter_if.sv | 31 +++
 rtl/apb_master_arbiter_rr_arbiter.sv | 15 +
 rtl/apb_master_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg: FSM states, APB phase encoding and width helper
package apb_master_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  // Phase bits are {PSELx, PENABLE}
  typedef enum logic [1:0] {PH_IDLE = 2'b00, PH_SETUP = 2'b10, PH_ACCESS = 2'b11} apb_phase_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester, response and APB completer signals
interface apb_master_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*AWIDTH-1:0] req_addr;
  logic [NREQ*DWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DWIDTH-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   PSELx;
  logic                   PENABLE;
  logic [AWIDTH-1:0]      PADDR;
  logic                   PWRITE;
  logic [DWIDTH-1:0]      PWDATA;
  logic [DWIDTH-1:0]      PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSELx, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);
  logic [NREQ-1:0] rot, low;
  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back
  assign rot   = NREQ'({req_i, req_i} >> ptr_i);
  assign low   = rot & (-rot);
  assign gnt_o = NREQ'(({low, low} << ptr_i) >> NREQ);
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB completer with PREADY timeout
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESETn,
  apb_master_arbiter_if.master bus
);
  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT + 1);
  state_e            state_q;
  apb_phase_e        phase_q;
  logic [PW-1:0]     owner_q, owner_d, rr_q;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt, rdy_q, rsp_q;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (.req_i(bus.req_valid), .ptr_i(rr_q), .gnt_o(gnt));

  always_comb begin
    owner_d = '0;
    addr_d  = '0;
    write_d = 1'b0;
    wdata_d = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        owner_d = PW'(i);
        addr_d  = bus.req_addr[i*AWIDTH +: AWIDTH];
        write_d = bus.req_write[i];
        wdata_d = bus.req_wdata[i*DWIDTH +: DWIDTH];
      end
  end

  // The IDLE cycle showing req_ready is the accept cycle; arbitration is skipped there
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q <= IDLE;
      phase_q <= PH_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= '0;
      rsp_q   <= '0;
    end else begin
      rdy_q <= '0;
      rsp_q <= '0;
      case (state_q)
        IDLE:
          if (rdy_q != '0) begin
            phase_q <= PH_SETUP;
            state_q <= SETUP;
          end else if (|bus.req_valid) begin
            rdy_q   <= gnt;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
          end
        SETUP: begin
          phase_q <= PH_ACCESS;
          cnt_q   <= CW'(1);
          state_q <= ACCESS;
        end
        ACCESS:
          if (bus.PREADY || cnt_q == CW'(TIMEOUT)) begin
            phase_q <= PH_IDLE;
            state_q <= RESP;
            rsp_q   <= NREQ'(1) << owner_q;
            err_q   <= bus.PREADY ? bus.PSLVERR : 1'b1;
            rdata_q <= (bus.PREADY && !write_q) ? bus.PRDATA : '0;
          end else cnt_q <= cnt_q + CW'(1);
        RESP: begin
          rr_q    <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.PSELx     = phase_q[1];
  assign bus.PENABLE   = phase_q[0];
  assign bus.PADDR     = addr_q;
  assign bus.PWRITE    = write_q;
  assign bus.PWDATA    = wdata_q;
endmodule
